// File: rtl/axis_dc_filter_ctrl.sv
// Sequencer for the lock-in DC filter: quarter-period sc_zero strobes, FAST/SLOW tau gear shift,
// manual DC override and DC lock monitor. Optional overrange freeze: define DC_CTRL_OVR_FREEZE_EN.
module axis_dc_filter_ctrl #(
  parameter int S_AXIS_DATA_WIDTH   = 16,
  parameter int QCNT_WIDTH          = 16,
  parameter int LOCK_COUNT          = 8,
  parameter int UNLOCK_FACTOR_SHIFT = 3
`ifdef DC_CTRL_OVR_FREEZE_EN
  , parameter int OVR_HOLD          = 1024
`endif
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic [S_AXIS_DATA_WIDTH-1:0] S_AXIS_tdata,
  input  logic                         S_AXIS_tvalid,
  input  logic                         phase_sync,
  input  logic [QCNT_WIDTH-1:0]        qper,
  input  logic [1:0]                   mode,
  input  logic [31:0]                  tau_fast,
  input  logic [31:0]                  tau_slow,
  input  logic [31:0]                  dc_manual,
  input  logic [31:0]                  lock_tol,
  input  logic [31:0]                  mdc_in,
`ifdef DC_CTRL_OVR_FREEZE_EN
  input  logic [S_AXIS_DATA_WIDTH-1:0] ovr_thresh,
`endif
  output logic                         sc_zero,
  output logic [31:0]                  dc_tau,
  output logic [31:0]                  dc,
  output logic                         dc_locked,
  output logic [2:0]                   state_dbg
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FAST   = 3'd1,
    ST_SLOW   = 3'd2,
    ST_MANUAL = 3'd3,
    ST_HOLD   = 3'd4
  } state_e;

  localparam int LCW  = $clog2(LOCK_COUNT + 1);
  localparam int TOLW = 33 + UNLOCK_FACTOR_SHIFT;

  state_e                state, next_state;
  logic [QCNT_WIDTH-1:0] qc, qeff;
  logic [1:0]            sc_cnt;
  logic [LCW-1:0]        lock_cnt, lock_cnt_next;
  logic [31:0]           prev_mdc;
  logic [32:0]           delta, delta_abs;
  logic                  wrap, active, emit, eval, in_tol, unlock, enter_fast, next_active;
  logic                  ovr_active;

  assign qeff   = (qper < QCNT_WIDTH'(2)) ? QCNT_WIDTH'(2) : qper;
  assign wrap   = S_AXIS_tvalid && !phase_sync && (state != ST_IDLE) && (qc >= qeff - 1'b1);
  assign active = (state == ST_FAST) || (state == ST_SLOW);
  // A pending mode change swallows the strobe, so it never races a lock evaluation.
  assign emit   = wrap && active && (mode == 2'd1) && !ovr_active;
  assign eval   = emit && (sc_cnt == 2'd3);

  assign delta     = {mdc_in[31], mdc_in} - {prev_mdc[31], prev_mdc};
  assign delta_abs = delta[32] ? -delta : delta;
  assign in_tol    = TOLW'(delta_abs) <= TOLW'(lock_tol);
  assign unlock    = TOLW'(delta_abs) > (TOLW'(lock_tol) << UNLOCK_FACTOR_SHIFT);

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    lock_cnt_next = lock_cnt;
    if (eval) begin
      if (!in_tol)                           lock_cnt_next = '0;
      else if (lock_cnt != LCW'(LOCK_COUNT)) lock_cnt_next = lock_cnt + 1'b1;
    end
    if (ovr_active) lock_cnt_next = '0;
  end

  always_comb begin
    next_state = state;
    unique case (mode)
      2'd0: next_state = ST_IDLE;
      2'd2: next_state = ST_MANUAL;
      2'd3: next_state = ST_HOLD;
      default: begin
        unique case (state)
          ST_FAST: if (lock_cnt_next == LCW'(LOCK_COUNT)) next_state = ST_SLOW;
          ST_SLOW: if (eval && unlock)                    next_state = ST_FAST;
          default:                                        next_state = ST_FAST;
        endcase
      end
    endcase
  end

  assign enter_fast  = (next_state == ST_FAST) && (state != ST_FAST);
  assign next_active = (next_state == ST_FAST) || (next_state == ST_SLOW);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state     <= ST_IDLE;
      qc        <= '0;
      sc_cnt    <= '0;
      lock_cnt  <= '0;
      prev_mdc  <= '0;
      sc_zero   <= 1'b0;
      dc_tau    <= '0;
      dc        <= '0;
      dc_locked <= 1'b0;
    end else begin
      state <= next_state;

      if (phase_sync)                              qc <= '0;
      else if (S_AXIS_tvalid && state != ST_IDLE)  qc <= wrap ? '0 : qc + 1'b1;

      sc_zero <= emit;

      if (phase_sync || enter_fast) sc_cnt <= '0;
      else if (emit)                sc_cnt <= sc_cnt + 2'd1;

      if (eval) prev_mdc <= mdc_in;

      lock_cnt  <= (next_active && !enter_fast) ? lock_cnt_next : '0;
      dc_locked <= next_active && !enter_fast && (lock_cnt_next == LCW'(LOCK_COUNT));

      unique case (state)
        ST_FAST:   dc_tau <= {1'b0, tau_fast[30:0]};
        ST_SLOW:   dc_tau <= {1'b0, tau_slow[30:0]};
        ST_MANUAL: dc_tau <= 32'h8000_0000;
        default:   dc_tau <= '0;
      endcase

      if (state == ST_MANUAL) dc <= dc_manual;
    end
  end

  assign state_dbg = state;

`ifdef DC_CTRL_OVR_FREEZE_EN
  localparam int HCW = $clog2(OVR_HOLD + 1);

  logic [HCW-1:0]               hold_cnt;
  logic [S_AXIS_DATA_WIDTH-1:0] tdata_abs;
  logic                         sample_ovr;
  logic                         unused_bits;

  // Negative full scale has no positive twin, so it is flagged explicitly as saturated.
  assign tdata_abs  = S_AXIS_tdata[S_AXIS_DATA_WIDTH-1] ? (~S_AXIS_tdata + 1'b1) : S_AXIS_tdata;
  assign sample_ovr = S_AXIS_tvalid &&
                      ((tdata_abs >= ovr_thresh) ||
                       (S_AXIS_tdata == {1'b1, {(S_AXIS_DATA_WIDTH-1){1'b0}}}));

  always_ff @(posedge aclk or posedge areset) begin
    if (areset)                hold_cnt <= '0;
    else if (sample_ovr)       hold_cnt <= HCW'(OVR_HOLD);
    else if (hold_cnt != '0)   hold_cnt <= hold_cnt - 1'b1;
  end

  assign ovr_active  = (hold_cnt != '0);
  assign unused_bits = ^{tau_fast[31], tau_slow[31]};
`else
  logic unused_bits;
  assign ovr_active  = 1'b0;
  assign unused_bits = ^{tau_fast[31], tau_slow[31], S_AXIS_tdata};
`endif

endmodule

// File: doc/axis_dc_filter_ctrl.md
Name: axis_dc_filter_ctrl

Overview:
Sequencer and configurator for the lock-in DC filter stage. Generates the quarter-period sc_zero strobes from the sample stream and drives dc_tau/dc. Runs a gear-shift state machine: fast tau until the DC estimate settles, then slow tau, plus a manual DC override. Sits between the ADC sample stream / PS config registers and the DC filter's control inputs, and monitors the filter's DC debug output for lock.

Parameters:
S_AXIS_DATA_WIDTH, 16, sample width on S_AXIS.
QCNT_WIDTH, 16, width of the quarter-period sample counter.
LOCK_COUNT, 8, consecutive in-tolerance 4-strobe periods required for lock.
UNLOCK_FACTOR_SHIFT, 3, drop back to FAST if |delta| > (lock_tol << this).

Ports:
aclk  in  1  clock; all logic is on the rising edge.
areset  in  1  asynchronous, active-high reset.
S_AXIS_tdata  in  S_AXIS_DATA_WIDTH  ADC sample (signed); used only by the optional feature.
S_AXIS_tvalid  in  1  sample strobe; the counter advances only on valid.
phase_sync  in  1  one-cycle pulse; realigns the quarter counter to 0.
qper  in  QCNT_WIDTH  samples per quarter period (unsigned).
mode  in  2  0=OFF, 1=AUTO, 2=MANUAL, 3=HOLD.
tau_fast  in  32  Q31 fast tau; bit31 is ignored.
tau_slow  in  32  Q31 slow tau; bit31 is ignored.
dc_manual  in  32  Q22 manual DC value.
lock_tol  in  32  unsigned tolerance on the DC delta, same scaling as mdc_in.
mdc_in  in  32  signed DC estimate returned from the filter's debug output.
sc_zero  out  1  quarter-period strobe to the filter.
dc_tau  out  32  tau to the filter; bit31=1 selects manual DC.
dc  out  32  manual DC to the filter.
dc_locked  out  1  DC estimate is settled.
state_dbg  out  3  current state encoding.

Behaviour:
- Reset values: sc_zero=0, dc_tau=0, dc=0, dc_locked=0, state=IDLE (0), counters 0, prev_mdc 0.
- Quarter counter qc:
  - On tvalid: qc <= (qc >= qeff-1) ? 0 : qc+1, where qeff = max(qper,2).
  - On wrap, sc_zero is registered high for exactly one cycle (1-cycle latency after the wrapping valid). Otherwise sc_zero=0.
  - Because qeff >= 2, strobes are never in back-to-back cycles, so the filter always gets its non-strobe update cycle.
- phase_sync: qc <= 0, no strobe that cycle. It has priority over tvalid and qc wrap.
- sc_zero gating: strobes are forced to 0 in IDLE, MANUAL and HOLD. The counter keeps running in every state except IDLE.
- States: IDLE(0), FAST(1), SLOW(2), MANUAL(3), HOLD(4).
  - Any state -> IDLE when mode=0; -> MANUAL when mode=2; -> HOLD when mode=3. Each takes effect the cycle after mode changes.
  - mode=1 from IDLE/MANUAL/HOLD -> FAST, clearing the lock counter and dc_locked.
  - FAST -> SLOW when the lock counter reaches LOCK_COUNT.
  - SLOW -> FAST when |delta| > (lock_tol << UNLOCK_FACTOR_SHIFT).
- Outputs by state (registered, 1 cycle after the state):
  - IDLE: dc_tau=0.
  - FAST: dc_tau={0,tau_fast[30:0]}.
  - SLOW: dc_tau={0,tau_slow[30:0]}.
  - MANUAL: dc_tau=32'h8000_0000, dc=dc_manual.
  - HOLD: dc_tau=0, which freezes the filter's auto DC.
  - dc holds its last value outside MANUAL.
- Lock monitor, evaluated on every 4th emitted strobe (a 2-bit strobe counter is cleared on phase_sync and on entry to FAST):
  - delta = mdc_in - prev_mdc, computed at 33 bits; prev_mdc <= mdc_in.
  - |delta| <= lock_tol: lock counter increments, saturating at LOCK_COUNT. Otherwise it clears to 0.
  - dc_locked = 1 while in FAST/SLOW with the counter at LOCK_COUNT; it drops the cycle the counter clears.
  - In MANUAL/HOLD/IDLE, dc_locked=0.
- Simultaneous events: a mode change and a lock evaluation in the same cycle resolve to the mode change. The tau update from a FAST->SLOW switch appears 1 cycle after the evaluating strobe.
- Reset mid-operation: everything returns to reset values asynchronously. The first strobe after release comes after qeff valid samples.

Optional Feature:
DC_CTRL_OVR_FREEZE_EN.
- Defined: adds input ovr_thresh (S_AXIS_DATA_WIDTH, unsigned) and parameter OVR_HOLD (default 1024).
  - A valid sample with |S_AXIS_tdata| >= ovr_thresh, with -full-scale treated as saturated, loads a hold counter with OVR_HOLD.
  - While the hold counter is nonzero: strobes are suppressed, the lock counter clears and dc_locked=0. The state is unchanged.
  - The hold counter decrements per cycle.
- Undefined: no port, no gating; S_AXIS_tdata is unused.

Test Plan:
- Reset, then mode=1, qper=4, tvalid=1 continuously -> state FAST, dc_tau=tau_fast&31'h7FFFFFFF, sc_zero high one cycle every 4 cycles, first strobe 5 cycles after the first valid.
- qper=1 -> strobes every 2 valids, never adjacent.
- qper=0 -> same as qper=1: strobes every 2 valids, never adjacent.
- AUTO, lock_tol=4, mdc_in constant 0x1000 -> after 8 in-tolerance 4-strobe evaluations: dc_locked=1, state SLOW, dc_tau=tau_slow.
- Then mdc_in steps by +0x40 (>4<<3) -> at the next evaluation: dc_locked=0, state FAST.
- mode=2, dc_manual=0x0012_3400 -> dc_tau=0x8000_0000, dc=0x0012_3400, sc_zero stays 0.
- mode=3 -> dc_tau=0, no strobes, dc still 0x0012_3400.
- phase_sync pulse at qc=2 with qper=4 -> no strobe that cycle, next strobe 4 valids later.
- areset asserted mid-FAST -> outputs 0 immediately (asynchronous). With DC_CTRL_OVR_FREEZE_EN defined, ovr_thresh=8000, OVR_HOLD=16 and one sample of 0x8000 -> strobes are absent for 16 cycles and dc_locked=0.
